// File: rtl/exu_alu_cmt_tx.sv
// Purpose  : ALU-to-commit transmitter; in-order FIFO of resolved ALU results with ebreak drain/halt and retire counter.
// Latency  : 1 cycle from input handshake to cmt_o_valid (no fall-through); sustained 1/cycle.
// Backpress: alu_i_ready drops when full, draining, halted or flushing; head fields hold while cmt_o_ready=0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   alu_i_*                  resolved ALU instruction in (valid/ready)
//   flush                    drop all buffered, uncommitted entries
//   cmt_o_*                  head entry out to commit (valid/ready)
//   halted                   high once the ebreak entry has committed, until reset
//   occupancy                number of valid FIFO entries
//   instret                  count of committed entries (wraps at 2^64)

`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module exu_alu_cmt_tx #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   // ALU side
   input  logic                     alu_i_valid,
   output logic                     alu_i_ready,
   input  logic [`PC_SIZE-1:0]      alu_i_pc,
   input  logic [`INSTR_SIZE-1:0]   alu_i_instr,
   input  logic                     alu_i_pc_vld,
   input  logic [`XLEN-1:0]         alu_i_imm,
   input  logic                     alu_i_bjp,
   input  logic                     alu_i_bjp_prdt,
   input  logic                     alu_i_ebreak,
   input  logic                     flush,
   // commit side
   output logic                     cmt_o_valid,
   input  logic                     cmt_o_ready,
   output logic [`PC_SIZE-1:0]      cmt_o_pc,
   output logic [`INSTR_SIZE-1:0]   cmt_o_instr,
   output logic                     cmt_o_pc_vld,
   output logic [`XLEN-1:0]         cmt_o_imm,
   output logic                     cmt_o_bjp,
   output logic                     cmt_o_bjp_prdt,
   output logic                     cmt_o_ebreak,
   // status
   output logic                     halted,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [63:0]              instret
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [`PC_SIZE-1:0]    pc;
      logic [`INSTR_SIZE-1:0] instr;
      logic                   pc_vld;
      logic [`XLEN-1:0]       imm;
      logic                   bjp;
      logic                   bjp_prdt;
      logic                   ebreak;
   } entry_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   entry_t        mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   state_t        state;
   logic          halted_q;
   logic [63:0]   instret_q;

   logic          empty;
   logic          full;
   logic          enq;
   logic          deq;
   entry_t        head;
   entry_t        in_entry;

   // Extra wrap bit: equal pointers mean empty, equal index with differing wrap bit means full.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // rst term keeps ready low for the whole time reset is held.
   assign alu_i_ready = !rst && !full && (state == ST_RUN) && !flush;
   assign cmt_o_valid = !empty && (state != ST_HALT);

   assign enq = alu_i_valid && alu_i_ready;
   assign deq = cmt_o_valid && cmt_o_ready;

   assign head = mem[rd_ptr[AW-1:0]];

   assign in_entry.pc       = alu_i_pc;
   assign in_entry.instr    = alu_i_instr;
   assign in_entry.pc_vld   = alu_i_pc_vld;
   assign in_entry.imm      = alu_i_imm;
   assign in_entry.bjp      = alu_i_bjp;
   assign in_entry.bjp_prdt = alu_i_bjp_prdt;
   assign in_entry.ebreak   = alu_i_ebreak;

   assign cmt_o_pc       = head.pc;
   assign cmt_o_instr    = head.instr;
   assign cmt_o_pc_vld   = head.pc_vld;
   assign cmt_o_imm      = head.imm;
   assign cmt_o_bjp      = head.bjp;
   assign cmt_o_bjp_prdt = head.bjp_prdt;
   assign cmt_o_ebreak   = head.ebreak;

   assign occupancy = wr_ptr - rd_ptr;
   assign halted    = halted_q;
   assign instret   = instret_q;

   // Storage, pointers, retire counter and trap FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         state     <= ST_RUN;
         halted_q  <= 1'b0;
         instret_q <= '0;
      end else begin
         if (enq) begin
            mem[wr_ptr[AW-1:0]] <= in_entry;
         end

         // A flush collapses the FIFO onto the post-dequeue read pointer, so a
         // same-cycle commit still retires while everything behind it is dropped.
         // In HALT deq is zero and flush is ignored, freezing the contents.
         if (flush && (state != ST_HALT)) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, deq};
            wr_ptr <= rd_ptr + {{AW{1'b0}}, deq};
         end else begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, deq};
            wr_ptr <= wr_ptr + {{AW{1'b0}}, enq};
         end

         if (deq) begin
            instret_q <= instret_q + 64'd1;
         end

         case (state)
            ST_RUN: begin
               if (enq && alu_i_ebreak) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Committing the ebreak wins over a concurrent flush.
               if (deq && head.ebreak) begin
                  state    <= ST_HALT;
                  halted_q <= 1'b1;
               end else if (flush) begin
                  state <= ST_RUN;
               end
            end
            ST_HALT: begin
               state    <= ST_HALT;
               halted_q <= 1'b1;
            end
            default: begin
               state    <= ST_RUN;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exu_alu_cmt_tx.sv
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_exu_alu_cmt_tx;

   logic                    clk;
   logic                    rst;
   logic                    alu_i_valid;
   logic                    alu_i_ready;
   logic [`PC_SIZE-1:0]     alu_i_pc;
   logic [`INSTR_SIZE-1:0]  alu_i_instr;
   logic                    alu_i_pc_vld;
   logic [`XLEN-1:0]        alu_i_imm;
   logic                    alu_i_bjp;
   logic                    alu_i_bjp_prdt;
   logic                    alu_i_ebreak;
   logic                    flush;
   logic                    cmt_o_valid;
   logic                    cmt_o_ready;
   logic [`PC_SIZE-1:0]     cmt_o_pc;
   logic [`INSTR_SIZE-1:0]  cmt_o_instr;
   logic                    cmt_o_pc_vld;
   logic [`XLEN-1:0]        cmt_o_imm;
   logic                    cmt_o_bjp;
   logic                    cmt_o_bjp_prdt;
   logic                    cmt_o_ebreak;
   logic                    halted;
   logic [1:0]              occupancy;
   logic [63:0]             instret;

   int checks = 0;
   int errors = 0;

   exu_alu_cmt_tx #(.DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .alu_i_valid    (alu_i_valid),
      .alu_i_ready    (alu_i_ready),
      .alu_i_pc       (alu_i_pc),
      .alu_i_instr    (alu_i_instr),
      .alu_i_pc_vld   (alu_i_pc_vld),
      .alu_i_imm      (alu_i_imm),
      .alu_i_bjp      (alu_i_bjp),
      .alu_i_bjp_prdt (alu_i_bjp_prdt),
      .alu_i_ebreak   (alu_i_ebreak),
      .flush          (flush),
      .cmt_o_valid    (cmt_o_valid),
      .cmt_o_ready    (cmt_o_ready),
      .cmt_o_pc       (cmt_o_pc),
      .cmt_o_instr    (cmt_o_instr),
      .cmt_o_pc_vld   (cmt_o_pc_vld),
      .cmt_o_imm      (cmt_o_imm),
      .cmt_o_bjp      (cmt_o_bjp),
      .cmt_o_bjp_prdt (cmt_o_bjp_prdt),
      .cmt_o_ebreak   (cmt_o_ebreak),
      .halted         (halted),
      .occupancy      (occupancy),
      .instret        (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic eb);
      alu_i_valid  = v;
      alu_i_pc     = pc;
      alu_i_instr  = pc ^ 32'h0000_0013;
      alu_i_pc_vld = v;
      alu_i_imm    = pc + 32'd16;
      alu_i_bjp    = 1'b0;
      alu_i_bjp_prdt = 1'b0;
      alu_i_ebreak = eb;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   localparam logic [31:0] BASE = 32'h8000_0000;

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      cmt_o_ready = 1'b0;
      drive(1'b0, 32'h0, 1'b0);

      // Reset values while rst is held.
      #2 rst = 1'b1;
      #1;
      chk("rst_ready",     alu_i_ready, 0);
      chk("rst_valid",     cmt_o_valid, 0);
      chk("rst_pc",        cmt_o_pc, 0);
      chk("rst_instr",     cmt_o_instr, 0);
      chk("rst_imm",       cmt_o_imm, 0);
      chk("rst_ebreak",    cmt_o_ebreak, 0);
      chk("rst_halted",    halted, 0);
      chk("rst_occ",       occupancy, 0);
      chk("rst_instret",   instret, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_ready", alu_i_ready, 1);

      // Streaming: 8 back-to-back, ready held high.
      cmt_o_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         drive(1'b1, BASE + 32'(4 * n), 1'b0);
         chk("stream_ready", alu_i_ready, 1);
         tick();
         chk("stream_valid",   cmt_o_valid, 1);
         chk("stream_pc",      cmt_o_pc, BASE + 32'(4 * n));
         chk("stream_imm",     cmt_o_imm, BASE + 32'(4 * n) + 32'd16);
         chk("stream_occ",     occupancy, 1);
         chk("stream_instret", instret, 64'(n));
      end
      drive(1'b0, 32'h0, 1'b0);
      tick();
      chk("stream_end_occ",     occupancy, 0);
      chk("stream_end_valid",   cmt_o_valid, 0);
      chk("stream_end_instret", instret, 8);

      // Backpressure: 3 offered, 2 fit.
      cmt_o_ready = 1'b0;
      drive(1'b1, 32'h100, 1'b0);
      tick();
      drive(1'b1, 32'h104, 1'b0);
      tick();
      drive(1'b1, 32'h108, 1'b0);
      #1;
      chk("bp_full_ready", alu_i_ready, 0);
      chk("bp_full_occ",   occupancy, 2);
      chk("bp_head_pc",    cmt_o_pc, 32'h100);
      tick();
      chk("bp_hold_occ",   occupancy, 2);
      chk("bp_hold_pc",    cmt_o_pc, 32'h100);
      chk("bp_hold_valid", cmt_o_valid, 1);
      cmt_o_ready = 1'b1;
      #1;
      chk("bp_full_deq_ready", alu_i_ready, 0);
      tick();
      chk("bp_second_pc", cmt_o_pc, 32'h104);
      chk("bp_second_occ", occupancy, 1);
      chk("bp_space_ready", alu_i_ready, 1);
      tick();
      chk("bp_third_pc",  cmt_o_pc, 32'h108);
      chk("bp_third_occ", occupancy, 1);
      drive(1'b0, 32'h0, 1'b0);
      tick();
      chk("bp_end_occ",     occupancy, 0);
      chk("bp_end_instret", instret, 11);

      // Ebreak: A, B, ebreak C, then D must never enter.
      do_reset();
      cmt_o_ready = 1'b1;
      drive(1'b1, 32'h200, 1'b0);
      tick();
      drive(1'b1, 32'h204, 1'b0);
      tick();
      drive(1'b1, 32'h208, 1'b1);
      tick();
      drive(1'b1, 32'h20c, 1'b0);
      #1;
      chk("eb_drain_ready",  alu_i_ready, 0);
      chk("eb_head_pc",      cmt_o_pc, 32'h208);
      chk("eb_head_ebreak",  cmt_o_ebreak, 1);
      chk("eb_not_halted",   halted, 0);
      tick();
      chk("eb_halted",  halted, 1);
      chk("eb_valid",   cmt_o_valid, 0);
      chk("eb_instret", instret, 3);
      chk("eb_occ",     occupancy, 0);
      for (int c = 0; c < 20; c++) begin
         flush = c[0];
         #1;
         chk("eb_hold_ready", alu_i_ready, 0);
         tick();
         chk("eb_hold_halted",  halted, 1);
         chk("eb_hold_valid",   cmt_o_valid, 0);
         chk("eb_hold_instret", instret, 3);
         chk("eb_hold_occ",     occupancy, 0);
      end
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);

      // Flush in DRAIN discards the ebreak and returns to RUN.
      do_reset();
      cmt_o_ready = 1'b0;
      drive(1'b1, 32'h300, 1'b0);
      tick();
      drive(1'b1, 32'h304, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      chk("fd_occ2", occupancy, 2);
      flush = 1'b1;
      #1;
      chk("fd_flush_ready", alu_i_ready, 0);
      tick();
      flush = 1'b0;
      #1;
      chk("fd_occ",     occupancy, 0);
      chk("fd_valid",   cmt_o_valid, 0);
      chk("fd_ready",   alu_i_ready, 1);
      chk("fd_halted",  halted, 0);
      chk("fd_instret", instret, 0);

      // Flush with a concurrent dequeue: head retires, second dropped.
      drive(1'b1, 32'h400, 1'b0);
      tick();
      drive(1'b1, 32'h404, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      chk("fq_occ2", occupancy, 2);
      chk("fq_head", cmt_o_pc, 32'h400);
      flush = 1'b1;
      cmt_o_ready = 1'b1;
      tick();
      flush = 1'b0;
      cmt_o_ready = 1'b0;
      #1;
      chk("fq_instret", instret, 1);
      chk("fq_occ",     occupancy, 0);
      chk("fq_valid",   cmt_o_valid, 0);

      // Async reset mid-cycle while in DRAIN with two entries.
      drive(1'b1, 32'h600, 1'b0);
      tick();
      drive(1'b1, 32'h604, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      chk("ar_pre_occ",   occupancy, 2);
      chk("ar_pre_ready", alu_i_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("ar_occ",     occupancy, 0);
      chk("ar_valid",   cmt_o_valid, 0);
      chk("ar_pc",      cmt_o_pc, 0);
      chk("ar_ebreak",  cmt_o_ebreak, 0);
      chk("ar_instret", instret, 0);
      chk("ar_halted",  halted, 0);
      chk("ar_ready",   alu_i_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("ar_release_ready", alu_i_ready, 1);

      // Ebreak commit in the flush cycle: HALT wins.
      drive(1'b1, 32'h500, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      chk("fh_occ1", occupancy, 1);
      flush = 1'b1;
      cmt_o_ready = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("fh_halted",  halted, 1);
      chk("fh_instret", instret, 1);
      chk("fh_valid",   cmt_o_valid, 0);
      chk("fh_ready",   alu_i_ready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
